// File: rtl/mem_io_pkg.sv
// Shared constants and helpers for the MEM-stage load/store unit.
package mem_io_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_MEM_WR   = 3'd1;
  localparam state_t S_MEM_RD   = 3'd2;
  localparam state_t S_MEM_DATA = 3'd3;
  localparam state_t S_IO_WAIT  = 3'd4;
  localparam state_t S_RESP     = 3'd5;

  // Access size
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Reserved funct3 values fall through to word
  function automatic size_e size_of(input logic [2:0] funct3);
    if (funct3 == F3_B || funct3 == F3_BU) begin
      return SZ_B;
    end else if (funct3 == F3_H || funct3 == F3_HU) begin
      return SZ_H;
    end
    return SZ_W;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
    return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_io_unit_align.sv
// Combinational lane steering: store byte enables / replication and load
// extraction with sign or zero extension.
module lsu_align
  import mem_io_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  size_e       sz;
  logic        is_unsigned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign sz          = size_of(funct3);
  assign is_unsigned = (funct3 == F3_BU) || (funct3 == F3_HU);
  assign ld_byte     = ld_raw[{addr_lo, 3'b000} +: 8];
  assign ld_half     = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];

  // Store path: enables and replicated data
  always_comb begin
    be       = 4'b1111;
    st_lanes = st_data;
    unique case (sz)
      SZ_B: begin
        be       = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load path: lane select and extension
  always_comb begin
    ld_data = ld_raw;
    unique case (sz)
      SZ_B: ld_data = is_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H: ld_data = is_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_io_unit.sv
// MEM-stage load/store unit: steers one request at a time to byte-enabled data
// memory or a memory-mapped IO channel, and stalls the pipeline while busy.
module mem_io_unit
  import mem_io_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] IO_BASE  = 32'hFFFF_FC00,
  parameter int unsigned       IO_CH    = 4,
  parameter int unsigned       IO_DW    = 16,
  parameter int unsigned       CH_SHIFT = 4,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_err,
  output logic                    stall,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [3:0]              mem_be,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [IO_CH-1:0]        io_sel,
  output logic                    io_we,
  output logic                    io_re,
  output logic [IO_DW-1:0]        io_wdata,
  input  logic [IO_CH*IO_DW-1:0]  io_rdata,
  input  logic                    io_ack
);

  localparam int unsigned CH_W = (IO_CH > 1) ? $clog2(IO_CH) : 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TW-1:0]       cnt_q, cnt_d;

  logic                is_io, bad_ch, misal;
  logic [ADDR_W-1:0]   io_off, io_idx;
  logic [31:0]         io_lsb;
  logic [IO_DW-1:0]    io_slice;
  logic [DATA_W-1:0]   io_word, ld_raw, ld_data, st_lanes;
  logic [3:0]          st_be;
  logic                mem_on, io_on;

  logic [3:0]          unused_ld_be;
  logic [DATA_W-1:0]   unused_ld_lanes, unused_st_ld;

  // Request decode happens on the live request so errors resolve at accept
  assign is_io  = req_addr >= IO_BASE;
  assign io_off = req_addr - IO_BASE;
  assign io_idx = io_off >> CH_SHIFT;
  assign bad_ch = io_idx >= ADDR_W'(IO_CH);
  assign misal  = misaligned(size_of(req_funct3), req_addr[1:0]);

  // IO read data is zero-extended before the usual lane rules
  assign io_lsb   = 32'(ch_q) * IO_DW;
  assign io_slice = io_rdata[io_lsb +: IO_DW];
  always_comb begin
    io_word                = '0;
    io_word[IO_DW-1:0]     = io_slice;
  end
  assign ld_raw = (state_q == S_IO_WAIT) ? io_word : mem_rdata;

  lsu_align u_store_align (
    .funct3   (funct3_q),
    .addr_lo  (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_raw   ('0),
    .be       (st_be),
    .st_lanes (st_lanes),
    .ld_data  (unused_st_ld)
  );

  lsu_align u_load_align (
    .funct3   (funct3_q),
    .addr_lo  (addr_q[1:0]),
    .st_data  ('0),
    .ld_raw   (ld_raw),
    .be       (unused_ld_be),
    .st_lanes (unused_ld_lanes),
    .ld_data  (ld_data)
  );

  // Next-state and request latching
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ch_d     = ch_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          ch_d     = io_idx[CH_W-1:0];
          rdata_d  = '0;
          cnt_d    = '0;
          err_d    = misal || (is_io && bad_ch);
          if (misal || (is_io && bad_ch)) begin
            state_d = S_RESP;
          end else if (is_io) begin
            state_d = S_IO_WAIT;
          end else if (req_we) begin
            state_d = S_MEM_WR;
          end else begin
            state_d = S_MEM_RD;
          end
        end
      end
      S_MEM_WR:   state_d = S_RESP;
      S_MEM_RD:   state_d = S_MEM_DATA;
      S_MEM_DATA: begin
        rdata_d = ld_data;
        state_d = S_RESP;
      end
      S_IO_WAIT: begin
        // Ack wins over the timeout when both land in the same cycle
        if (io_ack) begin
          rdata_d = we_q ? '0 : ld_data;
          state_d = S_RESP;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ch_q     <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ch_q     <= ch_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode purely from state so reset clears them asynchronously
  assign req_ready  = (state_q == S_IDLE);
  assign stall      = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  assign mem_we    = (state_q == S_MEM_WR);
  assign mem_re    = (state_q == S_MEM_RD);
  assign mem_on    = mem_we || mem_re;
  assign mem_addr  = mem_on ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = mem_we ? st_be : 4'b0000;
  assign mem_wdata = mem_we ? st_lanes : '0;

  assign io_on    = (state_q == S_IO_WAIT);
  assign io_sel   = io_on ? (IO_CH'(1) << ch_q) : '0;
  assign io_we    = io_on && we_q;
  assign io_re    = io_on && !we_q;
  assign io_wdata = io_on ? wdata_q[IO_DW-1:0] : '0;

endmodule

// File: tb/tb_mem_io_unit.sv
// Randomised bench for mem_io_unit with a byte-level reference memory and a
// per-transaction timeline of expected outputs.
module tb_mem_io_unit;

  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
  localparam int IO_CH   = 4;
  localparam int IO_DW   = 16;
  localparam int TIMEOUT = 15;

  logic        clk, rst_n;
  logic        req_valid, req_we, req_ready, resp_valid, resp_err, stall;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, io_we, io_re, io_ack;
  logic [3:0]  mem_be, io_sel;
  logic [15:0] io_wdata;
  logic [63:0] io_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_b [0:255];
  logic [31:0] phys  [0:63];

  logic        chk_en;
  logic        exp_ready, exp_stall, exp_valid, exp_err;
  logic        exp_mem_we, exp_mem_re, exp_io_we, exp_io_re;
  logic [31:0] exp_rdata, exp_mem_addr, exp_mem_wdata;
  logic [3:0]  exp_mem_be, exp_io_sel;
  logic [15:0] exp_io_wdata;

  mem_io_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .io_sel     (io_sel),
    .io_we      (io_we),
    .io_re      (io_re),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_ack     (io_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Physical memory seen by the DUT: synchronous read, byte-enabled write
  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) phys[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    if (mem_re) mem_rdata <= phys[mem_addr[7:2]];
  end

  // Single compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, exp_ready);
      chk("stall", stall, exp_stall);
      chk("resp_valid", resp_valid, exp_valid);
      chk("mem_we", mem_we, exp_mem_we);
      chk("mem_re", mem_re, exp_mem_re);
      chk("io_sel", io_sel, exp_io_sel);
      chk("io_we", io_we, exp_io_we);
      chk("io_re", io_re, exp_io_re);
      if (exp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", resp_err, exp_err);
      end
      if (exp_mem_we || exp_mem_re) chk("mem_addr", mem_addr, exp_mem_addr);
      if (exp_mem_we) begin
        chk("mem_be", mem_be, exp_mem_be);
        chk("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (exp_io_sel != 4'b0) chk("io_wdata", io_wdata, exp_io_wdata);
    end
  end

  function automatic int nb(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] w,
                                      input logic [1:0] lo);
    int n;
    logic [31:0] mask, v;
    n = nb(f3);
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w >> (8 * lo)) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] m;
    m = 4'((32'd1 << nb(f3)) - 32'd1);
    return m << lo;
  endfunction

  function automatic logic [31:0] lanes_of(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nb(f3);
    for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
  endfunction

  task automatic set_idle_exp();
    exp_ready = 1'b1; exp_stall = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
    exp_mem_we = 1'b0; exp_mem_re = 1'b0; exp_io_sel = 4'b0;
    exp_io_we = 1'b0; exp_io_re = 1'b0; exp_rdata = '0;
  endtask

  // One transaction; entered and left at posedge+1 of an idle cycle.
  // ack_at: cycle after accept on which io_ack is raised (0 or >TIMEOUT = never).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_at,
                         output logic [31:0] got_rd, output logic got_err,
                         output logic [31:0] m_rd, output logic m_err);
    int n, ch, resp_cyc;
    bit io, pre_err, acked, io_on;
    logic [1:0]  lo;
    logic [7:0]  a8;
    logic [31:0] aw, ioword;
    logic [63:0] iov;
    n   = nb(f3);
    lo  = addr[1:0];
    aw  = addr & ~32'd3;
    a8  = aw[7:0];
    io  = addr >= IO_BASE;
    ch  = io ? int'((addr - IO_BASE) >> 4) : 0;
    pre_err = ((addr % n) != 0) || (io && ch >= IO_CH);
    acked   = (ack_at >= 1) && (ack_at <= TIMEOUT);
    iov     = {$urandom, $urandom};
    ioword  = (io && !pre_err) ? 32'((iov >> (IO_DW * ch)) & 64'hFFFF) : 32'd0;
    m_err   = pre_err || (io && !acked);
    if (pre_err) resp_cyc = 1;
    else if (io) resp_cyc = (acked ? ack_at : TIMEOUT) + 1;
    else resp_cyc = we ? 2 : 3;
    m_rd = '0;
    if (!m_err && !we) m_rd = io ? ext(f3, ioword, lo) : ext(f3, ref_word(a8), lo);
    if (!pre_err && !io && we) begin
      for (int i = 0; i < n; i++) ref_b[addr[7:0] + i] = wd[8*i +: 8];
    end
    got_rd  = 'x;
    got_err = 1'bx;
    for (int c = 0; c <= resp_cyc; c++) begin
      exp_ready     = (c == 0);
      exp_stall     = (c != 0);
      exp_valid     = (c == resp_cyc);
      exp_err       = m_err;
      exp_rdata     = m_rd;
      exp_mem_we    = !io && !pre_err && we && (c == 1);
      exp_mem_re    = !io && !pre_err && !we && (c == 1);
      exp_mem_addr  = aw;
      exp_mem_be    = be_of(f3, lo);
      exp_mem_wdata = lanes_of(f3, wd);
      io_on         = io && !pre_err && (c >= 1) && (c < resp_cyc);
      exp_io_sel    = io_on ? 4'(1 << ch) : 4'b0;
      exp_io_we     = io_on && we;
      exp_io_re     = io_on && !we;
      exp_io_wdata  = wd[15:0];
      if (c == 0) begin
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        io_rdata  = iov;
      end else begin
        // Busy-time requests must be ignored
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
      if (io && !pre_err) io_ack = (c == ack_at);
      else io_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == resp_cyc) begin
        got_rd  = resp_rdata;
        got_err = resp_err;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    io_ack    = 1'b0;
    set_idle_exp();
  endtask

  initial begin : main
    logic [31:0] rd, mrd, a;
    logic        er, mer;
    int          ack;
    chk_en = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    io_ack = 1'b0; io_rdata = '0; mem_rdata = '0;
    set_idle_exp();
    for (int i = 0; i < 256; i++) ref_b[i] = 8'($urandom);
    for (int k = 0; k < 64; k++) phys[k] = ref_word(8'(4 * k));

    #3;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_strobes", {mem_we, mem_re, mem_be}, 6'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_io", {io_sel, io_we, io_re, io_wdata}, 22'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // LB sign-extends the top byte of word 0x10
    ref_b[16] = 8'h00; ref_b[17] = 8'h00; ref_b[18] = 8'h00; ref_b[19] = 8'h80;
    phys[4] = 32'h8000_0000;
    run_txn(1'b0, 3'd0, 32'h13, 32'd0, 0, rd, er, mrd, mer);
    chk("lb_model", mrd, 32'hFFFF_FF80);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    chk("lb_err", er, 1'b0);

    // SH to upper half
    chk("sh_be_model", be_of(3'd1, 2'd2), 4'b1100);
    chk("sh_wdata_model", lanes_of(3'd1, 32'h1234_ABCD), 32'hABCD_ABCD);
    run_txn(1'b1, 3'd1, 32'h2, 32'h1234_ABCD, 0, rd, er, mrd, mer);
    chk("sh_err", er, 1'b0);

    // Misaligned LW
    run_txn(1'b0, 3'd2, 32'h6, 32'd0, 0, rd, er, mrd, mer);
    chk("lw_mis_err", er, 1'b1);
    chk("lw_mis_rdata", rd, 32'd0);

    // SW to channel 1, ack on third wait cycle
    run_txn(1'b1, 3'd2, IO_BASE + 32'h10, 32'h0000_00A5, 3, rd, er, mrd, mer);
    chk("sw_io_err", er, 1'b0);

    // LHU timeout, then ack exactly on the last wait cycle
    run_txn(1'b0, 3'd5, IO_BASE, 32'd0, 0, rd, er, mrd, mer);
    chk("lhu_to_err", er, 1'b1);
    chk("lhu_to_rdata", rd, 32'd0);
    run_txn(1'b0, 3'd5, IO_BASE, 32'd0, TIMEOUT, rd, er, mrd, mer);
    chk("lhu_ack15_err", er, 1'b0);
    chk("lhu_ack15_rdata", rd, mrd);

    // Reset during IO_WAIT
    chk_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd5; req_addr = IO_BASE; io_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    chk("midrst_io_re_before", io_re, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_io_sel", io_sel, 4'b0);
    chk("midrst_io_re", io_re, 1'b0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("postrst_resp_valid", resp_valid, 1'b0);
      chk("postrst_req_ready", req_ready, 1'b1);
    end
    @(posedge clk); #1;
    set_idle_exp();
    chk_en = 1'b1;

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) < 4) a = IO_BASE + 32'($urandom_range(0, 16 * 6 - 1));
      else a = 32'($urandom_range(0, 255));
      ack = $urandom_range(0, TIMEOUT + 2);
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, ack,
              rd, er, mrd, mer);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
